// File: rtl/fifo_access_sched.sv
// Push/pop scheduler for a one-op-per-cycle FIFO: round-robin writers, one reader.
// Define FIFO_SCHED_CHK_EN to add the sticky o_sched_err consistency checker.
module fifo_access_sched #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 15,
   localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_wr_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
   output logic [NUM_REQ-1:0]            o_wr_gnt,
   input  logic                          i_rd_req,
   output logic                          o_rd_gnt,
   output logic                          o_rd_valid,
   output logic [DATA_WIDTH-1:0]         o_rd_data,
   output logic                          o_fifo_push,
   output logic                          o_fifo_pop,
   output logic [DATA_WIDTH-1:0]         o_fifo_din,
   input  logic [DATA_WIDTH-1:0]         i_fifo_dout,
   input  logic                          i_fifo_full,
   input  logic                          i_fifo_empty,
`ifdef FIFO_SCHED_CHK_EN
   output logic                          o_sched_err,
`endif
   output logic [OCC_W-1:0]              o_occupancy
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   typedef enum logic {OpPush, OpPop} op_e;

   logic [NUM_REQ-1:0]    r_wr_gnt;
   logic                  r_push;
   logic                  r_pop;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_fifo_din;
   logic [OCC_W-1:0]      r_occ;
   logic [PTR_W-1:0]      r_rr_ptr;
   op_e                   r_last_op;

   logic [NUM_REQ-1:0]    w_req_elig;
   logic [PTR_W-1:0]      w_sel;
   logic                  w_sel_found;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [OCC_W-1:0]      w_occ_proj;
   logic                  w_push_elig;
   logic                  w_pop_elig;
   logic                  w_do_push;
   logic                  w_do_pop;

   logic [NUM_REQ-1:0]    w_wr_gnt_nxt;
   logic [DATA_WIDTH-1:0] w_fifo_din_nxt;
   logic [PTR_W-1:0]      w_rr_ptr_nxt;
   op_e                   w_last_op_nxt;

   // A requester granted this cycle still shows its old request; mask it out.
   assign w_req_elig = i_wr_req & ~r_wr_gnt;

   // Occupancy as it will be after the op already issued this cycle retires.
   always_comb begin
      w_occ_proj = r_occ;
      if (r_push) begin
         w_occ_proj = r_occ + OCC_W'(1);
      end else if (r_pop) begin
         w_occ_proj = r_occ - OCC_W'(1);
      end
   end

   always_comb begin
      int unsigned idx;
      w_sel       = '0;
      w_sel_found = 1'b0;
      idx         = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(r_rr_ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!w_sel_found && w_req_elig[PTR_W'(idx)]) begin
            w_sel       = PTR_W'(idx);
            w_sel_found = 1'b1;
         end
      end
   end

   assign w_sel_data = i_wr_data[w_sel*DATA_WIDTH +: DATA_WIDTH];

   assign w_push_elig = w_sel_found && (w_occ_proj < OCC_W'(FIFO_DEPTH)) && !i_fifo_full;
   assign w_pop_elig  = i_rd_req && !r_pop && (w_occ_proj != '0) && !i_fifo_empty;

   always_comb begin
      w_do_push      = 1'b0;
      w_do_pop       = 1'b0;
      w_wr_gnt_nxt   = '0;
      w_fifo_din_nxt = '0;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_last_op_nxt  = r_last_op;

      if (w_push_elig && w_pop_elig) begin
         w_do_push = (r_last_op == OpPop);
         w_do_pop  = (r_last_op == OpPush);
      end else begin
         w_do_push = w_push_elig;
         w_do_pop  = w_pop_elig;
      end

      if (w_do_push) begin
         w_wr_gnt_nxt   = NUM_REQ'(1) << w_sel;
         w_fifo_din_nxt = w_sel_data;
         w_last_op_nxt  = OpPush;
         if (w_sel == PTR_W'(NUM_REQ - 1)) begin
            w_rr_ptr_nxt = '0;
         end else begin
            w_rr_ptr_nxt = w_sel + PTR_W'(1);
         end
      end else if (w_do_pop) begin
         w_last_op_nxt = OpPop;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_gnt   <= '0;
         r_push     <= 1'b0;
         r_pop      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_fifo_din <= '0;
         r_occ      <= '0;
         r_rr_ptr   <= '0;
         r_last_op  <= OpPop;
      end else begin
         r_wr_gnt   <= w_wr_gnt_nxt;
         r_push     <= w_do_push;
         r_pop      <= w_do_pop;
         r_rd_valid <= r_pop;
         r_fifo_din <= w_fifo_din_nxt;
         r_occ      <= w_occ_proj;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_last_op  <= w_last_op_nxt;
      end
   end

   assign o_wr_gnt    = r_wr_gnt;
   assign o_rd_gnt    = r_pop;
   assign o_rd_valid  = r_rd_valid;
   assign o_rd_data   = i_fifo_dout;
   assign o_fifo_push = r_push;
   assign o_fifo_pop  = r_pop;
   assign o_fifo_din  = r_fifo_din;
   assign o_occupancy = r_occ;

`ifdef FIFO_SCHED_CHK_EN
   logic r_full_mis;
   logic r_empty_mis;
   logic r_sched_err;
   logic w_full_mis;
   logic w_empty_mis;
   logic w_multi_gnt;
   logic w_err_nxt;

   // Counter and FIFO flags change on the same edge, so a lasting disagreement is a fault.
   assign w_full_mis  = (r_occ == OCC_W'(FIFO_DEPTH)) && !i_fifo_full;
   assign w_empty_mis = (r_occ == '0) && !i_fifo_empty;
   assign w_multi_gnt = (r_wr_gnt & (r_wr_gnt - NUM_REQ'(1))) != '0;
   assign w_err_nxt   = r_sched_err || (w_full_mis && r_full_mis) ||
                        (w_empty_mis && r_empty_mis) || w_multi_gnt || (r_push && r_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full_mis  <= 1'b0;
         r_empty_mis <= 1'b0;
         r_sched_err <= 1'b0;
      end else begin
         r_full_mis  <= w_full_mis;
         r_empty_mis <= w_empty_mis;
         r_sched_err <= w_err_nxt;
      end
   end

   assign o_sched_err = r_sched_err;
`endif

`ifndef SYNTHESIS
   a_strobe_excl : assert property (@(posedge i_clk) disable iff (i_rst) !(r_push && r_pop));
   a_gnt_onehot  : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_wr_gnt));
   a_occ_bound   : assert property (@(posedge i_clk) disable iff (i_rst)
                                    r_occ <= OCC_W'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed bench for fifo_access_sched with a small behavioural FIFO attached.
// Build with FIFO_SCHED_CHK_EN defined to also exercise o_sched_err.
module tb_fifo_access_sched;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;

   logic           clk;
   logic           rst;
   logic [NR-1:0]  wr_req;
   logic [NR*DW-1:0] wr_data;
   logic [NR-1:0]  wr_gnt;
   logic           rd_req;
   logic           rd_gnt;
   logic           rd_valid;
   logic [DW-1:0]  rd_data;
   logic           fifo_push;
   logic           fifo_pop;
   logic [DW-1:0]  fifo_din;
   logic [DW-1:0]  fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;
   logic [3:0]     occupancy;
`ifdef FIFO_SCHED_CHK_EN
   logic           sched_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic force_nofull;

   fifo_access_sched #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (15)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_wr_req     (wr_req),
      .i_wr_data    (wr_data),
      .o_wr_gnt     (wr_gnt),
      .i_rd_req     (rd_req),
      .o_rd_gnt     (rd_gnt),
      .o_rd_valid   (rd_valid),
      .o_rd_data    (rd_data),
      .o_fifo_push  (fifo_push),
      .o_fifo_pop   (fifo_pop),
      .o_fifo_din   (fifo_din),
      .i_fifo_dout  (fifo_dout),
      .i_fifo_full  (fifo_full),
      .i_fifo_empty (fifo_empty),
`ifdef FIFO_SCHED_CHK_EN
      .o_sched_err  (sched_err),
`endif
      .o_occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FIFO: 15 usable entries, flags and dout change on the op edge.
   logic [DW-1:0] mem [16];
   logic [3:0]    m_wp;
   logic [3:0]    m_rp;
   int            m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_wp      <= 4'd0;
         m_rp      <= 4'd0;
         m_cnt     <= 0;
         fifo_dout <= '0;
      end else if (fifo_push) begin
         mem[m_wp] <= fifo_din;
         m_wp      <= m_wp + 4'd1;
         m_cnt     <= m_cnt + 1;
      end else if (fifo_pop) begin
         fifo_dout <= mem[m_rp];
         m_rp      <= m_rp + 4'd1;
         m_cnt     <= m_cnt - 1;
      end
   end

   assign fifo_full  = (m_cnt >= 15) && !force_nofull;
   assign fifo_empty = (m_cnt == 0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      wr_req = '0;
      rd_req = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"},   32'(wr_gnt),    32'h0);
      check({tag, "_push"},  32'(fifo_push), 32'h0);
      check({tag, "_pop"},   32'(fifo_pop),  32'h0);
      check({tag, "_din"},   32'(fifo_din),  32'h0);
      check({tag, "_rdgnt"}, 32'(rd_gnt),    32'h0);
      check({tag, "_rdval"}, 32'(rd_valid),  32'h0);
      check({tag, "_occ"},   32'(occupancy), 32'h0);
`ifdef FIFO_SCHED_CHK_EN
      check({tag, "_err"},   32'(sched_err), 32'h0);
`endif
   endtask

   logic [3:0] exp_gnt [5];
   logic [7:0] exp_din [5];
   logic [7:0] exp_rd  [4];
   int         n_gnt;

   initial begin
      exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_din = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
      exp_rd  = '{8'h01, 8'h02, 8'h03, 8'h04};
      force_nofull = 1'b0;
      wr_data = '0;
      wr_req  = '0;
      rd_req  = 1'b0;
      rst     = 1'b1;

      do_reset();
      check_idle("rst");

      // Single push of 0xA5 from requester 0.
      wr_req = 4'b0001;
      wr_data[7:0] = 8'hA5;
      step(1);
      check("a_gnt",  32'(wr_gnt),    32'h1);
      check("a_push", 32'(fifo_push), 32'h1);
      check("a_din",  32'(fifo_din),  32'hA5);
      check("a_occ0", 32'(occupancy), 32'h0);
      wr_req = '0;
      step(1);
      check("a_occ1", 32'(occupancy), 32'h1);
      check("a_idle", 32'(fifo_push), 32'h0);

      // All four requesting: rotation 0,1,2,3,0 on consecutive cycles.
      do_reset();
      wr_data = {8'h04, 8'h03, 8'h02, 8'h01};
      wr_req  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("b_gnt", 32'(wr_gnt),   32'(exp_gnt[i]));
         check("b_din", 32'(fifo_din), 32'(exp_din[i]));
      end
      wr_req = '0;
      step(1);
      check("b_push", 32'(fifo_push), 32'h0);
      check("b_occ",  32'(occupancy), 32'h5);

      // Push and pop contend at occupancy 5; last op was a push, so pop goes first.
      wr_req = 4'b0001;
      wr_data[7:0] = 8'h55;
      rd_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check("d_pop",   32'(fifo_pop),  32'((i % 2) == 0));
         check("d_push",  32'(fifo_push), 32'((i % 2) == 1));
         check("d_occ",   32'(occupancy), ((i % 2) == 0) ? 32'h5 : 32'h4);
         check("d_rdval", 32'(rd_valid),  32'((i % 2) == 1));
         if (rd_valid) begin
            check("d_rddat", 32'(rd_data), 32'(exp_rd[i / 2]));
         end
         if (fifo_push) begin
            check("d_din", 32'(fifo_din), 32'h55);
         end
      end
      wr_req = '0;
      rd_req = 1'b0;
`ifdef FIFO_SCHED_CHK_EN
      check("d_err", 32'(sched_err), 32'h0);
`endif

      // Fill to 15 with 0x10.. from requester 0, then a blocked requester 2.
      do_reset();
      wr_data[7:0] = 8'h10;
      wr_req = 4'b0001;
      for (int i = 0; i < 32; i++) begin
         step(1);
         if (wr_gnt[0]) wr_data[7:0] = wr_data[7:0] + 8'd1;
      end
      wr_req = '0;
      check("c_occ15",  32'(occupancy), 32'd15);
      check("c_nopush", 32'(fifo_push), 32'h0);
`ifdef FIFO_SCHED_CHK_EN
      force_nofull = 1'b1;
      step(1);
      check("x_err0", 32'(sched_err), 32'h0);
      step(1);
      check("x_err1", 32'(sched_err), 32'h1);
      force_nofull = 1'b0;
      step(2);
      check("x_sticky", 32'(sched_err), 32'h1);
`endif
      wr_req = 4'b0100;
      wr_data[23:16] = 8'h77;
      n_gnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (wr_gnt != '0) n_gnt++;
      end
      check("c_blocked", 32'(n_gnt), 32'h0);
      rd_req = 1'b1;
      step(1);
      check("c_rdgnt", 32'(rd_gnt),   32'h1);
      check("c_pop",   32'(fifo_pop), 32'h1);
      check("c_gnt0",  32'(wr_gnt),   32'h0);
      rd_req = 1'b0;
      step(1);
      check("c_rdval", 32'(rd_valid), 32'h1);
      check("c_rddat", 32'(rd_data),  32'h10);
      check("c_gnt1",  32'(wr_gnt),   32'h0);
      check("c_occ14", 32'(occupancy), 32'd14);
      step(1);
      check("c_gnt2",  32'(wr_gnt),   32'h4);
      check("c_din2",  32'(fifo_din), 32'h77);
      wr_req = '0;
      step(1);
      check("c_occ_re", 32'(occupancy), 32'd15);

      // Pop waits on an empty FIFO, then serves the pushed 0x3C.
      do_reset();
`ifdef FIFO_SCHED_CHK_EN
      check("e_err_clr", 32'(sched_err), 32'h0);
`endif
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("e_nogrant", 32'(rd_gnt), 32'h0);
      end
      wr_req = 4'b0001;
      wr_data[7:0] = 8'h3C;
      step(1);
      check("e_push",   32'(fifo_push), 32'h1);
      check("e_rdgnt0", 32'(rd_gnt),    32'h0);
      wr_req = '0;
      step(1);
      check("e_rdgnt1", 32'(rd_gnt),    32'h0);
      check("e_occ1",   32'(occupancy), 32'h1);
      step(1);
      check("e_rdgnt2", 32'(rd_gnt),    32'h1);
      rd_req = 1'b0;
      step(1);
      check("e_rdval", 32'(rd_valid),  32'h1);
      check("e_rddat", 32'(rd_data),   32'h3C);
      check("e_occ0",  32'(occupancy), 32'h0);

      // Reset while a push is in flight.
      do_reset();
      wr_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      wr_req  = 4'b1111;
      step(2);
      check("f_inflight", 32'(fifo_push), 32'h1);
      rst = 1'b1;
      step(1);
      check_idle("f_rst");
      rst    = 1'b0;
      wr_req = '0;
      step(1);
      check("f_occ", 32'(occupancy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
